// File: rtl/player_move_ctrl_pkg.sv
// Shared types and screen geometry for the player movement controller.
// Direction codes double as bit indices into the synchronized input vector {right,left,down,up}.
package momentum_pkg;

  localparam int SPRITE_W = 10;
  localparam int SPRITE_H = 10;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  typedef enum logic [2:0] {
    INIT_DRAW,
    IDLE,
    MOVE,
    REQ,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

endpackage

// File: rtl/player_move_ctrl_if.sv
// Controller-to-drawer link: position/erase coordinates plus a level request answered by a done pulse.
// master = movement controller, slave = sprite drawer.
interface player_move_ctrl_if #(
  parameter int POS_W = 11
);
  logic             draw_req;
  logic             draw_done;
  logic [POS_W-1:0] pos_x;
  logic [POS_W-1:0] pos_y;
  logic [POS_W-1:0] prev_x;
  logic [POS_W-1:0] prev_y;

  modport master (
    output draw_req, pos_x, pos_y, prev_x, prev_y,
    input  draw_done
  );

  modport slave (
    input  draw_req, pos_x, pos_y, prev_x, prev_y,
    output draw_done
  );
endinterface

// File: rtl/player_move_ctrl_dir_sync.sv
// Two-flop synchronizer for the four direction levels followed by an up>down>left>right encoder.
// Latency: two clk edges from raw input to lvl/valid/dir; no backpressure.
module dir_sync
  import momentum_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       dir_up,
  input  logic       dir_down,
  input  logic       dir_left,
  input  logic       dir_right,
  output logic [3:0] lvl,
  output logic       valid,
  output dir_t       dir
);

  logic [3:0] meta;
  logic [3:0] sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= {dir_right, dir_left, dir_down, dir_up};
      sync <= meta;
    end
  end

  assign lvl   = sync;
  assign valid = |sync;

  always_comb begin
    dir = DIR_RIGHT;
    if (sync[DIR_UP])
      dir = DIR_UP;
    else if (sync[DIR_DOWN])
      dir = DIR_DOWN;
    else if (sync[DIR_LEFT])
      dir = DIR_LEFT;
  end

endmodule

// File: rtl/player_move_ctrl.sv
// Grid-stepped player position with one redraw request per move; raw press to pos/draw_req in 4 edges.
// draw_req holds pos/prev frozen until draw_done; define HOLD_REPEAT_EN for auto-repeat while held.
module player_move_ctrl
  import momentum_pkg::*;
#(
  parameter int POS_W         = 11,
  parameter int STEP          = SPRITE_W,
  parameter int X_MAX         = SCREEN_W - SPRITE_W,
  parameter int Y_MAX         = SCREEN_H - SPRITE_H,
  parameter int X_INIT        = 0,
  parameter int Y_INIT        = 0,
  parameter int REPEAT_CYCLES = 25_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dir_up,
  input  logic                dir_down,
  input  logic                dir_left,
  input  logic                dir_right,
  player_move_ctrl_if.master  drw
);

  state_t           state;
  state_t           state_nxt;
  dir_t             dir_q;
  dir_t             dir_win;
  logic             dir_vld;
  logic [3:0]       dir_lvl;
  logic [POS_W-1:0] pos_x;
  logic [POS_W-1:0] pos_y;
  logic [POS_W-1:0] prev_x;
  logic [POS_W-1:0] prev_y;
  logic [POS_W-1:0] step_x;
  logic [POS_W-1:0] step_y;
  logic             at_wall;
  logic             held;
  logic             rpt_fire;
  logic             draw_req;

  dir_sync u_dir_sync (
    .clk       (clk),
    .reset     (reset),
    .dir_up    (dir_up),
    .dir_down  (dir_down),
    .dir_left  (dir_left),
    .dir_right (dir_right),
    .lvl       (dir_lvl),
    .valid     (dir_vld),
    .dir       (dir_win)
  );

  // Bounds are checked before adding/subtracting so the unsigned result never wraps.
  always_comb begin
    step_x = pos_x;
    step_y = pos_y;
    case (dir_q)
      DIR_UP:    step_y = (pos_y >= POS_W'(STEP))          ? pos_y - POS_W'(STEP) : '0;
      DIR_DOWN:  step_y = (pos_y <= POS_W'(Y_MAX - STEP))  ? pos_y + POS_W'(STEP) : POS_W'(Y_MAX);
      DIR_LEFT:  step_x = (pos_x >= POS_W'(STEP))          ? pos_x - POS_W'(STEP) : '0;
      DIR_RIGHT: step_x = (pos_x <= POS_W'(X_MAX - STEP))  ? pos_x + POS_W'(STEP) : POS_W'(X_MAX);
      default:   ;
    endcase
    at_wall = (step_x == pos_x) && (step_y == pos_y);
  end

  assign held = dir_lvl[dir_q];

`ifdef HOLD_REPEAT_EN
  localparam int CNT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  logic [CNT_W-1:0] rpt_cnt;

  always_ff @(posedge clk) begin
    if (reset || (state != HOLD) || (state_nxt != HOLD))
      rpt_cnt <= '0;
    else
      rpt_cnt <= rpt_cnt + CNT_W'(1);
  end

  assign rpt_fire = (rpt_cnt == CNT_W'(REPEAT_CYCLES - 1));
`else
  assign rpt_fire = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      INIT_DRAW: if (drw.draw_done) state_nxt = IDLE;
      IDLE:      if (dir_vld) state_nxt = MOVE;
      MOVE:      state_nxt = at_wall ? HOLD : REQ;
      REQ:       if (drw.draw_done) state_nxt = HOLD;
      HOLD: begin
        // Release of the latched direction wins; another held direction is picked up from IDLE.
        if (!held)
          state_nxt = IDLE;
        else if (rpt_fire)
          state_nxt = MOVE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT_DRAW;
      dir_q    <= DIR_UP;
      pos_x    <= POS_W'(X_INIT);
      pos_y    <= POS_W'(Y_INIT);
      prev_x   <= POS_W'(X_INIT);
      prev_y   <= POS_W'(Y_INIT);
      draw_req <= 1'b0;
    end else begin
      state    <= state_nxt;
      draw_req <= (state_nxt == INIT_DRAW) || (state_nxt == REQ);
      if ((state == IDLE) && dir_vld)
        dir_q <= dir_win;
      if ((state == MOVE) && !at_wall) begin
        prev_x <= pos_x;
        prev_y <= pos_y;
        pos_x  <= step_x;
        pos_y  <= step_y;
      end
    end
  end

  assign drw.draw_req = draw_req;
  assign drw.pos_x    = pos_x;
  assign drw.pos_y    = pos_y;
  assign drw.prev_x   = prev_x;
  assign drw.prev_y   = prev_y;

endmodule
